// File: rtl/compare_event_monitor.sv
// compare_event_monitor: debounced A>B alarm with hysteresis, saturating outcome counters and sticky flag error
module compare_event_monitor #(
  parameter int SET_COUNT   = 3,
  parameter int CLEAR_COUNT = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  input  logic                   Valid_In,
  input  logic                   A_Less_Than_B_In,
  input  logic                   A_Equal_To_B_In,
  input  logic                   A_Greater_Than_B_In,
  input  logic                   Clear_In,
  output logic                   Alarm_Out,
  output logic                   Alarm_Rise_Out,
  output logic                   Alarm_Fall_Out,
  output logic [COUNT_WIDTH-1:0] Less_Count_Out,
  output logic [COUNT_WIDTH-1:0] Equal_Count_Out,
  output logic [COUNT_WIDTH-1:0] Greater_Count_Out,
  output logic                   Error_Out
);
  typedef enum logic [1:0] {LOW, ARMING, HIGH, DISARMING} state_t;
  localparam logic [7:0] SET_N = SET_COUNT[7:0];
  localparam logic [7:0] CLR_N = CLEAR_COUNT[7:0];
  state_t r_state, w_state_next;
  logic [7:0] r_run, w_run_next, w_run_inc;
  logic [2:0] w_flags;
  logic w_onehot, w_good, w_lt, w_eq, w_gt, w_alarm_next;
  logic r_alarm, r_rise, r_fall, r_err;
  logic [COUNT_WIDTH-1:0] r_lt_cnt, r_eq_cnt, r_gt_cnt;
  assign w_flags  = {A_Less_Than_B_In, A_Equal_To_B_In, A_Greater_Than_B_In};
  assign w_onehot = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
  assign w_good   = Valid_In && w_onehot;
  assign w_lt     = w_good && A_Less_Than_B_In;
  assign w_eq     = w_good && A_Equal_To_B_In;
  assign w_gt     = w_good && A_Greater_Than_B_In;
  assign w_run_inc = r_run + 8'd1;
  // Malformed or idle samples leave state and run untouched
  always_comb begin
    w_state_next = r_state;
    w_run_next   = r_run;
    case (r_state)
      LOW: if (w_gt) begin
        w_state_next = (SET_N == 8'd1) ? HIGH : ARMING;
        w_run_next   = (SET_N == 8'd1) ? 8'd0 : 8'd1;
      end
      ARMING: if (w_gt) begin
        w_state_next = (w_run_inc == SET_N) ? HIGH : ARMING;
        w_run_next   = (w_run_inc == SET_N) ? 8'd0 : w_run_inc;
      end else if (w_good) begin
        w_state_next = LOW;
        w_run_next   = 8'd0;
      end
      HIGH: if (w_lt) begin
        w_state_next = (CLR_N == 8'd1) ? LOW : DISARMING;
        w_run_next   = (CLR_N == 8'd1) ? 8'd0 : 8'd1;
      end
      DISARMING: if (w_lt) begin
        w_state_next = (w_run_inc == CLR_N) ? LOW : DISARMING;
        w_run_next   = (w_run_inc == CLR_N) ? 8'd0 : w_run_inc;
      end else if (w_gt) begin
        w_state_next = HIGH;
        w_run_next   = 8'd0;
      end
      default: begin
        w_state_next = LOW;
        w_run_next   = 8'd0;
      end
    endcase
  end
  assign w_alarm_next = (w_state_next == HIGH) || (w_state_next == DISARMING);
  // Clear beats a same-cycle increment or error, but never touches the FSM
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      r_state  <= LOW;
      r_run    <= 8'd0;
      r_alarm  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_err    <= 1'b0;
      r_lt_cnt <= '0;
      r_eq_cnt <= '0;
      r_gt_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_run   <= w_run_next;
      r_alarm <= w_alarm_next;
      r_rise  <= w_alarm_next && !r_alarm;
      r_fall  <= !w_alarm_next && r_alarm;
      if (Clear_In) begin
        r_err    <= 1'b0;
        r_lt_cnt <= '0;
        r_eq_cnt <= '0;
        r_gt_cnt <= '0;
      end else begin
        if (Valid_In && !w_onehot) r_err <= 1'b1;
        if (w_lt && r_lt_cnt != '1) r_lt_cnt <= r_lt_cnt + 1'b1;
        if (w_eq && r_eq_cnt != '1) r_eq_cnt <= r_eq_cnt + 1'b1;
        if (w_gt && r_gt_cnt != '1) r_gt_cnt <= r_gt_cnt + 1'b1;
      end
    end
  end
  assign Alarm_Out         = r_alarm;
  assign Alarm_Rise_Out    = r_rise;
  assign Alarm_Fall_Out    = r_fall;
  assign Less_Count_Out    = r_lt_cnt;
  assign Equal_Count_Out   = r_eq_cnt;
  assign Greater_Count_Out = r_gt_cnt;
  assign Error_Out         = r_err;
endmodule
